// File: rtl/parallel2serial_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmitter.
package p2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } p2s_state_e;

  // Bit counter must index 0..WIDTH-1; never narrower than one bit.
  function automatic int bcnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  // Gap counter must index 0..GAP-1; kept at one bit even when GAP is 0.
  function automatic int gcnt_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/parallel2serial_if.sv
// Word-in / bit-out signal bundle of the serial link transmitter.
interface parallel2serial_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din_parallel;
  logic             din_valid;
  logic             din_ready;
  logic             dout_serial;
  logic             dout_valid;
  logic             dout_last;
  logic             busy;

  modport master (
    output din_parallel,
    output din_valid,
    input  din_ready,
    input  dout_serial,
    input  dout_valid,
    input  dout_last,
    input  busy
  );

  modport slave (
    input  din_parallel,
    input  din_valid,
    output din_ready,
    output dout_serial,
    output dout_valid,
    output dout_last,
    output busy
  );

endinterface

// File: rtl/parallel2serial.sv
// Serial link transmitter: holding register feeds an MSB-first shifter,
// with an optional idle gap between words so the receiver can re-arm.
module parallel2serial #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  parallel2serial_if.slave  bus
);

  import p2s_pkg::*;

  localparam int BW = bcnt_width(WIDTH);
  localparam int GW = gcnt_width(GAP);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
  localparam logic [GW-1:0] GCNT_ONE  = GW'(1);

  p2s_state_e       state_q,    state_d;
  logic [WIDTH-1:0] hold_q,     hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] sh_q,       sh_d;
  logic [BW-1:0]    bcnt_q,     bcnt_d;
  logic [GW-1:0]    gcnt_q,     gcnt_d;

  // Next-state logic: input accept, FSM sequencing and counter updates.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    bcnt_d     = bcnt_q;
    gcnt_d     = gcnt_q;

    // Accept needs an empty holder, and transfer needs a full one, so the
    // two updates to hold_vld below can never collide in the same cycle.
    if (bus.din_valid && !hold_vld_q) begin
      hold_d     = bus.din_parallel;
      hold_vld_d = 1'b1;
    end else begin
      hold_d     = hold_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_vld_q) begin
          sh_d       = hold_q;
          hold_vld_d = 1'b0;
          bcnt_d     = {BW{1'b0}};
          state_d    = ST_SHIFT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        bcnt_d = bcnt_q + BCNT_ONE;
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d = {BW{1'b0}};
          if (GAP > 0) begin
            gcnt_d  = {GW{1'b0}};
            state_d = ST_GAP;
          end else if (hold_vld_q) begin
            sh_d       = hold_q;
            hold_vld_d = 1'b0;
            state_d    = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q + GCNT_ONE;
        if (gcnt_q == GCNT_LAST) begin
          gcnt_d = {GW{1'b0}};
          if (hold_vld_q) begin
            sh_d       = hold_q;
            hold_vld_d = 1'b0;
            bcnt_d     = {BW{1'b0}};
            state_d    = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards both held and in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= {WIDTH{1'b0}};
      hold_vld_q <= 1'b0;
      sh_q       <= {WIDTH{1'b0}};
      bcnt_q     <= {BW{1'b0}};
      gcnt_q     <= {GW{1'b0}};
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  // Outputs decode registers only, so din_* never reaches them combinationally.
  assign bus.din_ready   = ~hold_vld_q;
  assign bus.dout_valid  = (state_q == ST_SHIFT);
  assign bus.dout_serial = (state_q == ST_SHIFT) & sh_q[WIDTH-1];
  assign bus.dout_last   = (state_q == ST_SHIFT) & (bcnt_q == BCNT_LAST);
  assign bus.busy        = (state_q != ST_IDLE) | hold_vld_q;

endmodule
